// File: rtl/pic_pkg.sv
// Shared definitions for the PIC read/write control block: init FSM states,
// read-select encoding, registered bus strobe bundle and ICW/OCW bit positions.
package pic_pkg;

  // Initialisation sequence tracker
  typedef enum logic [1:0] {
    ST_READY     = 2'd0,
    ST_WAIT_ICW2 = 2'd1,
    ST_WAIT_ICW3 = 2'd2,
    ST_WAIT_ICW4 = 2'd3
  } init_state_e;

  // Register returned on an a0=0 read
  typedef enum logic {
    SEL_IRR = 1'b0,
    SEL_ISR = 1'b1
  } rd_sel_e;

  // CPU-side strobes and address, sampled together once per clock
  typedef struct packed {
    logic cs_n;
    logic rd_n;
    logic wr_n;
    logic a0;
    logic inta_n;
  } bus_strb_t;

  localparam bus_strb_t STRB_IDLE = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, a0: 1'b0, inta_n: 1'b1};

  // ICW1 fields
  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_SEL  = 4;
  // ICW2 vector base occupies bits 7:3
  localparam int ICW2_BASE_LSB = 3;
  // OCW2/OCW3 are told apart by bits 4:3
  localparam int OCW_SEL_LSB = 3;
  // OCW3 fields
  localparam int OCW3_RIS = 0;
  localparam int OCW3_RR  = 1;
  localparam int OCW3_P   = 2;

  // An a0=0 write with bit 4 set restarts initialisation from any state
  function automatic logic is_icw1(input logic a0, input logic [7:0] data);
    return !a0 && data[ICW1_SEL];
  endfunction

endpackage

// File: rtl/pic_rw_ctrl_if.sv
// CPU bus side of the PIC read/write control block: strobes, address,
// data in both directions and the data-bus buffer controls.
interface pic_rw_ctrl_if;

  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a0;
  logic       inta_n;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       buf_en;
  logic       buf_dir;

  // CPU / bus driver side
  modport master (
    output cs_n, rd_n, wr_n, a0, inta_n, d_in,
    input  d_out, buf_en, buf_dir
  );

  // PIC control block side
  modport slave (
    input  cs_n, rd_n, wr_n, a0, inta_n, d_in,
    output d_out, buf_en, buf_dir
  );

endinterface

// File: rtl/pic_bus_sync.sv
// Registers the CPU strobes and a0 once per clock (the s-stage) and flags
// the wr_n rising edge and inta_n falling edge between consecutive samples.
module pic_bus_sync
  import pic_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  bus_strb_t strb_i,
  output bus_strb_t strb_s_o,
  output logic      wr_rise_o,
  output logic      inta_fall_o
);

  bus_strb_t strb_q;
  logic      wr_n_p_q;
  logic      inta_n_p_q;

  // Sample stage plus one-deep history for edge detection
  // NOTE: non-blocking assignments so every register sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_q     <= STRB_IDLE;
      wr_n_p_q   <= 1'b1;
      inta_n_p_q <= 1'b1;
    end else begin
      strb_q     <= strb_i;
      wr_n_p_q   <= strb_q.wr_n;
      inta_n_p_q <= strb_q.inta_n;
    end
  end

  assign strb_s_o    = strb_q;
  assign wr_rise_o   = strb_q.wr_n & ~wr_n_p_q;
  assign inta_fall_o = ~strb_q.inta_n & inta_n_p_q;

endmodule

// File: rtl/pic_rw_ctrl.sv
// PIC read/write control: decodes CPU reads, writes and INTA cycles,
// runs the ICW1..ICW4 initialisation sequence, holds IMR/OCW2/read-select,
// and drives read data, interrupt vectors and the data-bus buffer controls.
// VEC_MODE86=1 returns {icw2_base, irq_id} on the second INTA pulse, 0 returns 8'h00.
// Optional feature macro PIC_POLL_CMD_EN: OCW3 bit 2 arms a one-shot poll read.
module pic_rw_ctrl
  import pic_pkg::*;
#(
  parameter bit VEC_MODE86 = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  pic_rw_ctrl_if.slave        bus,
  input  logic [7:0]          irr_i,
  input  logic [7:0]          isr_i,
  input  logic [2:0]          irq_id_i,
  input  logic                irq_valid_i,
  output logic [7:0]          imr_o,
  output logic [4:0]          icw2_base_o,
  output logic [7:0]          icw3_o,
  output logic [7:0]          icw4_o,
  output logic                init_done_o,
  output logic                init_clr_o,
  output logic                ocw2_stb_o,
  output logic [7:0]          ocw2_o,
  output logic                inta_ack_o
);

  bus_strb_t strb_raw;
  bus_strb_t s;
  logic      wr_rise;
  logic      inta_fall;

  assign strb_raw = '{cs_n: bus.cs_n, rd_n: bus.rd_n, wr_n: bus.wr_n, a0: bus.a0, inta_n: bus.inta_n};

  pic_bus_sync u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .strb_i      (strb_raw),
    .strb_s_o    (s),
    .wr_rise_o   (wr_rise),
    .inta_fall_o (inta_fall)
  );

  // Configuration / FSM state
  init_state_e state_q, state_d;
  logic [7:0]  imr_q, imr_d;
  logic [4:0]  base_q, base_d;
  logic [7:0]  icw3_q, icw3_d;
  logic [7:0]  icw4_q, icw4_d;
  logic        sngl_q, sngl_d;
  logic        ic4_q, ic4_d;
  logic        init_done_q, init_done_d;
  rd_sel_e     sel_q, sel_d;
  logic [7:0]  ocw2_q, ocw2_d;
  logic        ocw2_stb_q, ocw2_stb_d;
  logic        init_clr_q, init_clr_d;

  // Bus datapath state
  logic [7:0]  din_s_q;
  logic [7:0]  wdata_q, wdata_d;
  logic        wa0_q, wa0_d;
  logic        wr_act_q;
  logic [1:0]  inta_cnt_q, inta_cnt_d;
  logic        inta_drv_q, inta_drv_d;
  logic        inta_ack_q, inta_ack_d;
  logic [7:0]  d_out_q, d_out_d;
  logic        buf_en_q, buf_en_d;
  logic        buf_dir_q, buf_dir_d;

`ifdef PIC_POLL_CMD_EN
  logic        poll_set;
  logic        poll_clr;
  logic        poll_arm_q, poll_arm_d;
  logic        poll_rd_q, poll_rd_d;
  logic        rd_act_q;
  logic        rd_end;
`else
  // Without poll support the pending-request flag has no consumer here
  logic        unused_irq_valid;
  assign unused_irq_valid = irq_valid_i;
`endif

  // Cycle decode from the s-stage; an accepted INTA cycle masks rd/wr decode
  logic inta_act;
  logic read_act;
  logic write_act;
  logic commit;

  assign inta_act  = ~s.inta_n & init_done_q;
  assign read_act  = ~inta_act & ~s.cs_n & ~s.rd_n & s.wr_n;
  assign write_act = ~inta_act & ~s.cs_n & ~s.wr_n & s.rd_n;
  // A write lands when wr_n releases after a clean (rd_n high, cs_n low) write cycle
  assign commit    = wr_rise & wr_act_q;

`ifdef PIC_POLL_CMD_EN
  assign rd_end = rd_act_q & ~read_act;
`endif

  // Initialisation FSM and command-register updates on each committed write
  // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    imr_d       = imr_q;
    base_d      = base_q;
    icw3_d      = icw3_q;
    icw4_d      = icw4_q;
    sngl_d      = sngl_q;
    ic4_d       = ic4_q;
    init_done_d = init_done_q;
    sel_d       = sel_q;
    ocw2_d      = ocw2_q;
    ocw2_stb_d  = 1'b0;
    init_clr_d  = 1'b0;
`ifdef PIC_POLL_CMD_EN
    poll_set    = 1'b0;
    poll_clr    = 1'b0;
`endif
    if (commit) begin
      if (is_icw1(wa0_q, wdata_q)) begin
        imr_d       = 8'h00;
        sel_d       = SEL_IRR;
        init_done_d = 1'b0;
        init_clr_d  = 1'b1;
        sngl_d      = wdata_q[ICW1_SNGL];
        ic4_d       = wdata_q[ICW1_IC4];
        state_d     = ST_WAIT_ICW2;
`ifdef PIC_POLL_CMD_EN
        poll_clr    = 1'b1;
`endif
      end else begin
        case (state_q)
          ST_WAIT_ICW2: begin
            if (wa0_q) begin
              base_d = wdata_q[7:ICW2_BASE_LSB];
              if (!sngl_q) begin
                state_d = ST_WAIT_ICW3;
              end else if (ic4_q) begin
                state_d = ST_WAIT_ICW4;
              end else begin
                state_d     = ST_READY;
                init_done_d = 1'b1;
              end
            end
          end
          ST_WAIT_ICW3: begin
            if (wa0_q) begin
              icw3_d = wdata_q;
              if (ic4_q) begin
                state_d = ST_WAIT_ICW4;
              end else begin
                state_d     = ST_READY;
                init_done_d = 1'b1;
              end
            end
          end
          ST_WAIT_ICW4: begin
            if (wa0_q) begin
              icw4_d      = wdata_q;
              state_d     = ST_READY;
              init_done_d = 1'b1;
            end
          end
          default: begin
            if (wa0_q) begin
              imr_d = wdata_q;
            end else if (wdata_q[OCW_SEL_LSB +: 2] == 2'b00) begin
              ocw2_d     = wdata_q;
              ocw2_stb_d = 1'b1;
            end else if (wdata_q[OCW_SEL_LSB +: 2] == 2'b01) begin
              if (wdata_q[OCW3_RR]) begin
                sel_d = rd_sel_e'(wdata_q[OCW3_RIS]);
              end
`ifdef PIC_POLL_CMD_EN
              poll_set = wdata_q[OCW3_P];
`endif
            end
          end
        endcase
      end
    end
  end

  // Write capture, INTA sequencing, read data and buffer control
  always_comb begin
    wdata_d    = wdata_q;
    wa0_d      = wa0_q;
    inta_cnt_d = inta_cnt_q;
    inta_drv_d = inta_act & inta_drv_q;
    inta_ack_d = 1'b0;
    d_out_d    = d_out_q;
    buf_en_d   = 1'b0;
    buf_dir_d  = 1'b0;
`ifdef PIC_POLL_CMD_EN
    poll_arm_d = poll_arm_q;
    poll_rd_d  = poll_rd_q;
`endif

    if (write_act) begin
      wdata_d = din_s_q;
      wa0_d   = s.a0;
    end

    // First pulse only counts; the second one returns the vector
    if (inta_fall && init_done_q) begin
      if (inta_cnt_q == 2'd1) begin
        inta_cnt_d = 2'd0;
        inta_drv_d = 1'b1;
        inta_ack_d = 1'b1;
        d_out_d    = VEC_MODE86 ? {base_q, irq_id_i} : 8'h00;
      end else begin
        inta_cnt_d = inta_cnt_q + 2'd1;
      end
    end

    if (inta_act) begin
      buf_en_d  = inta_drv_d;
      buf_dir_d = inta_drv_d;
    end else if (read_act) begin
      buf_en_d  = 1'b1;
      buf_dir_d = 1'b1;
      if (s.a0) begin
        d_out_d = imr_q;
      end else begin
        d_out_d = (sel_q == SEL_ISR) ? isr_i : irr_i;
      end
    end else if (write_act) begin
      buf_en_d = 1'b1;
    end

`ifdef PIC_POLL_CMD_EN
    if (poll_set) begin
      poll_arm_d = 1'b1;
    end
    if (poll_clr) begin
      poll_arm_d = 1'b0;
      poll_rd_d  = 1'b0;
    end
    if (read_act && poll_arm_q && !s.a0) begin
      d_out_d   = {irq_valid_i, 4'b0000, irq_id_i};
      poll_rd_d = 1'b1;
    end
    if (rd_end && poll_rd_q) begin
      poll_arm_d = 1'b0;
      poll_rd_d  = 1'b0;
      if (irq_valid_i) begin
        inta_ack_d = 1'b1;
      end
    end
`endif
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_READY;
      imr_q       <= 8'hFF;
      base_q      <= 5'd0;
      icw3_q      <= 8'h00;
      icw4_q      <= 8'h00;
      sngl_q      <= 1'b0;
      ic4_q       <= 1'b0;
      init_done_q <= 1'b0;
      sel_q       <= SEL_IRR;
      ocw2_q      <= 8'h00;
      ocw2_stb_q  <= 1'b0;
      init_clr_q  <= 1'b0;
      din_s_q     <= 8'h00;
      wdata_q     <= 8'h00;
      wa0_q       <= 1'b0;
      wr_act_q    <= 1'b0;
      inta_cnt_q  <= 2'd0;
      inta_drv_q  <= 1'b0;
      inta_ack_q  <= 1'b0;
      d_out_q     <= 8'h00;
      buf_en_q    <= 1'b0;
      buf_dir_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      imr_q       <= imr_d;
      base_q      <= base_d;
      icw3_q      <= icw3_d;
      icw4_q      <= icw4_d;
      sngl_q      <= sngl_d;
      ic4_q       <= ic4_d;
      init_done_q <= init_done_d;
      sel_q       <= sel_d;
      ocw2_q      <= ocw2_d;
      ocw2_stb_q  <= ocw2_stb_d;
      init_clr_q  <= init_clr_d;
      din_s_q     <= bus.d_in;
      wdata_q     <= wdata_d;
      wa0_q       <= wa0_d;
      wr_act_q    <= write_act;
      inta_cnt_q  <= inta_cnt_d;
      inta_drv_q  <= inta_drv_d;
      inta_ack_q  <= inta_ack_d;
      d_out_q     <= d_out_d;
      buf_en_q    <= buf_en_d;
      buf_dir_q   <= buf_dir_d;
    end
  end

`ifdef PIC_POLL_CMD_EN
  // Poll arming and read tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_arm_q <= 1'b0;
      poll_rd_q  <= 1'b0;
      rd_act_q   <= 1'b0;
    end else begin
      poll_arm_q <= poll_arm_d;
      poll_rd_q  <= poll_rd_d;
      rd_act_q   <= read_act;
    end
  end
`endif

  assign bus.d_out   = d_out_q;
  assign bus.buf_en  = buf_en_q;
  assign bus.buf_dir = buf_dir_q;
  assign imr_o       = imr_q;
  assign icw2_base_o = base_q;
  assign icw3_o      = icw3_q;
  assign icw4_o      = icw4_q;
  assign init_done_o = init_done_q;
  assign init_clr_o  = init_clr_q;
  assign ocw2_stb_o  = ocw2_stb_q;
  assign ocw2_o      = ocw2_q;
  assign inta_ack_o  = inta_ack_q;

endmodule

// File: tb/tb_pic_rw_ctrl.sv
// Self-checking bench for pic_rw_ctrl: directed scenarios followed by
// randomized bus traffic, compared against a command-level PIC model.
module tb_pic_rw_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pic_rw_ctrl_if bus ();

  logic [7:0] irr, isr;
  logic [2:0] irq_id;
  logic       irq_valid;
  logic [7:0] imr_o, icw3_o, icw4_o, ocw2_o;
  logic [4:0] icw2_base_o;
  logic       init_done_o, init_clr_o, ocw2_stb_o, inta_ack_o;

  pic_rw_ctrl #(.VEC_MODE86(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .irr_i       (irr),
    .isr_i       (isr),
    .irq_id_i    (irq_id),
    .irq_valid_i (irq_valid),
    .imr_o       (imr_o),
    .icw2_base_o (icw2_base_o),
    .icw3_o      (icw3_o),
    .icw4_o      (icw4_o),
    .init_done_o (init_done_o),
    .init_clr_o  (init_clr_o),
    .ocw2_stb_o  (ocw2_stb_o),
    .ocw2_o      (ocw2_o),
    .inta_ack_o  (inta_ack_o)
  );

  int errors = 0;
  int checks = 0;

  // Pulse counters observed mid-cycle
  int ack_seen = 0;
  int clr_seen = 0;
  int stb_seen = 0;
  always @(negedge clk) begin
    if (inta_ack_o) ack_seen <= ack_seen + 1;
    if (init_clr_o) clr_seen <= clr_seen + 1;
    if (ocw2_stb_o) stb_seen <= stb_seen + 1;
  end

  // Command-level reference model
  logic [7:0] m_imr, m_ocw2, m_icw3, m_icw4;
  logic [4:0] m_base;
  logic       m_done, m_isr_sel;
  int         m_inta;
  int         need[$];
  int         exp_ack = 0;
  int         exp_clr = 0;
  int         exp_stb = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_imr = 8'hFF; m_ocw2 = 8'h00; m_icw3 = 8'h00; m_icw4 = 8'h00;
    m_base = 5'd0; m_done = 1'b0; m_isr_sel = 1'b0; m_inta = 0;
    need.delete();
  endtask

  task automatic m_write(input logic a0, input logic [7:0] b);
    int w;
    if (!a0 && b[4]) begin
      m_imr = 8'h00; m_isr_sel = 1'b0; m_done = 1'b0; exp_clr++;
      need.delete();
      need.push_back(2);
      if (!b[1]) need.push_back(3);
      if (b[0]) need.push_back(4);
    end else if (need.size() != 0) begin
      if (a0) begin
        w = need.pop_front();
        if (w == 2) m_base = b[7:3];
        else if (w == 3) m_icw3 = b;
        else m_icw4 = b;
        if (need.size() == 0) m_done = 1'b1;
      end
    end else if (a0) begin
      m_imr = b;
    end else if (b[4:3] == 2'b00) begin
      m_ocw2 = b; exp_stb++;
    end else if (b[1]) begin
      m_isr_sel = b[0];
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".imr"},  32'(imr_o),       32'(m_imr));
    check({tag, ".base"}, 32'(icw2_base_o), 32'(m_base));
    check({tag, ".done"}, 32'(init_done_o), 32'(m_done));
    check({tag, ".ocw2"}, 32'(ocw2_o),      32'(m_ocw2));
    check({tag, ".icw3"}, 32'(icw3_o),      32'(m_icw3));
    check({tag, ".icw4"}, 32'(icw4_o),      32'(m_icw4));
  endtask

  task automatic bus_write(input logic a0, input logic [7:0] b);
    @(negedge clk);
    bus.a0 = a0; bus.d_in = b; bus.cs_n = 1'b0; bus.wr_n = 1'b0;
    repeat (3) @(negedge clk);
    check("wr.buf_en",  32'(bus.buf_en),  32'd1);
    check("wr.buf_dir", 32'(bus.buf_dir), 32'd0);
    bus.wr_n = 1'b1;
    @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (2) @(negedge clk);
    m_write(a0, b);
  endtask

  task automatic bus_read(input logic a0, output logic [7:0] got);
    @(negedge clk);
    bus.a0 = a0; bus.cs_n = 1'b0; bus.rd_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rd.buf_en",  32'(bus.buf_en),  32'd1);
    check("rd.buf_dir", 32'(bus.buf_dir), 32'd1);
    got = bus.d_out;
    bus.rd_n = 1'b1; bus.cs_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic read_and_check(input logic a0, input string tag);
    logic [7:0] got;
    logic [7:0] exp;
    exp = a0 ? m_imr : (m_isr_sel ? isr : irr);
    bus_read(a0, got);
    check(tag, 32'(got), 32'(exp));
  endtask

  task automatic inta_pulse(input string tag);
    logic second;
    second = 1'b0;
    if (m_done) begin
      m_inta++;
      if (m_inta == 2) begin second = 1'b1; m_inta = 0; exp_ack++; end
    end
    @(negedge clk);
    bus.inta_n = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, ".buf_en"}, 32'(bus.buf_en), 32'(second));
    if (second) begin
      check({tag, ".buf_dir"}, 32'(bus.buf_dir), 32'd1);
      check({tag, ".vec"},     32'(bus.d_out),   32'({m_base, irq_id}));
    end
    bus.inta_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    logic [7:0] imr_before;
    int op;

    bus.cs_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.a0 = 1'b0;
    bus.inta_n = 1'b1; bus.d_in = 8'h00;
    irr = 8'h00; isr = 8'h00; irq_id = 3'd0; irq_valid = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst.imr",      32'(imr_o),       32'hFF);
    check("rst.base",     32'(icw2_base_o), 32'h00);
    check("rst.done",     32'(init_done_o), 32'd0);
    check("rst.ocw2",     32'(ocw2_o),      32'h00);
    check("rst.d_out",    32'(bus.d_out),   32'h00);
    check("rst.buf_en",   32'(bus.buf_en),  32'd0);
    check("rst.buf_dir",  32'(bus.buf_dir), 32'd0);
    check("rst.pulses",   32'({init_clr_o, ocw2_stb_o, inta_ack_o}), 32'd0);
    rst_n = 1'b1;
    m_reset();

    // Single, with ICW4
    bus_write(1'b0, 8'h13); bus_write(1'b1, 8'h20); bus_write(1'b1, 8'h01);
    check("icw.done", 32'(init_done_o), 32'd1);
    check("icw.base", 32'(icw2_base_o), 32'h04);
    check("icw.imr",  32'(imr_o),       32'h00);
    check_state("icw");

    // Cascade sequence interrupted by a fresh ICW1 while waiting for ICW3
    bus_write(1'b0, 8'h11); bus_write(1'b1, 8'h40);
    bus_write(1'b0, 8'h08);               // a0=0 non-ICW1 in a wait state: ignored
    check_state("wait_ign");
    bus_write(1'b0, 8'h11);
    check("restart.clr", 32'(clr_seen), 32'(exp_clr));
    bus_write(1'b1, 8'h48); bus_write(1'b1, 8'h5C);
    check("cas.done_pre", 32'(init_done_o), 32'd0);
    bus_write(1'b1, 8'h01);
    check("cas.done", 32'(init_done_o), 32'd1);
    check("cas.icw3", 32'(icw3_o), 32'h5C);
    check_state("cas");

    // OCW1 write then IMR read
    bus_write(1'b1, 8'hA5);
    bus_read(1'b1, got);
    check("ocw1.rd", 32'(got), 32'hA5);

    // OCW3 read select
    isr = 8'h04; irr = 8'h30;
    bus_write(1'b0, 8'h0B);
    bus_read(1'b0, got);
    check("ocw3.isr", 32'(got), 32'h04);
    bus_write(1'b0, 8'h0A);
    bus_read(1'b0, got);
    check("ocw3.irr", 32'(got), 32'h30);

    // OCW2
    bus_write(1'b0, 8'h20);
    check("ocw2.val", 32'(ocw2_o), 32'h20);
    check("ocw2.stb", 32'(stb_seen), 32'(exp_stb));

    // INTA vector with base 4, level 3
    bus_write(1'b0, 8'h13); bus_write(1'b1, 8'h20); bus_write(1'b1, 8'h01);
    irq_id = 3'd3;
    inta_pulse("inta1");
    inta_pulse("inta2");
    check("inta.vec23", 32'(bus.d_out), 32'h23);
    check("inta.ack",   32'(ack_seen),  32'(exp_ack));

    // rd_n and wr_n low together: no drive, no commit
    imr_before = imr_o;
    @(negedge clk);
    bus.a0 = 1'b1; bus.d_in = 8'h5A; bus.cs_n = 1'b0; bus.rd_n = 1'b0; bus.wr_n = 1'b0;
    repeat (3) @(negedge clk);
    check("both.buf_en", 32'(bus.buf_en), 32'd0);
    bus.cs_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
    repeat (3) @(negedge clk);
    check("both.imr", 32'(imr_o), 32'(imr_before));

    // Reset in the middle of a write
    @(negedge clk);
    bus.a0 = 1'b1; bus.d_in = 8'h3C; bus.cs_n = 1'b0; bus.wr_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    bus.wr_n = 1'b1; bus.cs_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    check("rstw.imr", 32'(imr_o), 32'hFF);
    check_state("rstw");

    // Reset in the middle of an INTA pair discards the first pulse
    bus_write(1'b0, 8'h13); bus_write(1'b1, 8'h28); bus_write(1'b1, 8'h01);
    inta_pulse("half");
    do_reset();
    bus_write(1'b0, 8'h13); bus_write(1'b1, 8'h28); bus_write(1'b1, 8'h01);
    irq_id = 3'd6;
    inta_pulse("post1");
    inta_pulse("post2");

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 5));
      case (op)
        0: bus_write(1'($urandom_range(0, 1)), 8'($urandom));
        1: begin
             irr = 8'($urandom); isr = 8'($urandom);
             read_and_check(1'($urandom_range(0, 1)), "rnd.rd");
           end
        2: begin
             irq_id = 3'($urandom);
             inta_pulse("rnd.inta");
           end
        3: bus_write(1'b0, {5'b00001, 1'b0, 2'($urandom)});
        4: bus_write(1'b1, 8'($urandom));
        default: begin
             bus_write(1'b0, {3'($urandom), 1'b1, 2'b00, 2'($urandom)});
             bus_write(1'b1, 8'($urandom));
             bus_write(1'b1, 8'($urandom));
             bus_write(1'b1, 8'($urandom));
           end
      endcase
      check_state("rnd");
    end

    check("end.ack", 32'(ack_seen), 32'(exp_ack));
    check("end.clr", 32'(clr_seen), 32'(exp_clr));
    check("end.stb", 32'(stb_seen), 32'(exp_stb));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pic_rw_ctrl.md
PIC_RW_CTRL -- requirements
Module: pic_rw_ctrl

Interface
REQ-001 Parameter VEC_MODE86, default 1: 1 means 8086 two-pulse INTA vector format; 0 means vector disabled (d_out 8'h00 on INTA).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cs_n, rd_n, wr_n, a0, inta_n  in  1 each  CPU bus strobes/address, active-low strobes.
REQ-005 d_in  in  8  write data from data bus buffer.
REQ-006 d_out  out  8  read/vector data to data bus buffer.
REQ-007 buf_en  out  1  buffer drive enable; 0 = both buffer sides Z.
REQ-008 buf_dir  out  1  1 = internal->CPU (read/INTA), 0 = CPU->internal (write).
REQ-009 irr, isr  in  8 each  request/in-service registers from the priority block.
REQ-010 irq_id  in  3  highest-priority pending level; irq_valid  in  1.
REQ-011 imr  out  8  mask register; icw2_base  out  5  vector base.
REQ-012 init_done  out  1; init_clr  out  1-cycle pulse on ICW1.
REQ-013 ocw2_stb  out  1-cycle pulse; ocw2  out  8  last OCW2 byte.
REQ-014 inta_ack  out  1-cycle pulse on second INTA falling edge.

Function
REQ-015 Strobes and a0 registered once per clk (s-stage); all decode uses s-stage values.
REQ-016 Read active: cs_n=0, rd_n=0, wr_n=1; then buf_en=1, buf_dir=1 one clk after sampling.
REQ-017 Write active: cs_n=0, wr_n=0, rd_n=1; then buf_en=1, buf_dir=0 one clk after sampling; d_in captured every clk while active.
REQ-018 rd_n and wr_n both low with cs_n=0: buf_en=0, no commit, no read.
REQ-019 Write commits on the clk where s-stage wr_n goes 0->1 with cs_n low in the prior s-stage, using last captured byte.
REQ-020 Init FSM states READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4.
REQ-021 ICW1 (a0=0, bit4=1) accepted in any state: imr<=0, read select<=IRR, init_done<=0, init_clr pulse, latch SNGL=bit1, IC4=bit0, go WAIT_ICW2.
REQ-022 WAIT_ICW2, a0=1 write: icw2_base<=d[7:3]; next WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else READY.
REQ-023 WAIT_ICW3, a0=1 write: store icw3; next WAIT_ICW4 if IC4, else READY.
REQ-024 WAIT_ICW4, a0=1 write: store icw4; next READY; init_done<=1 on every entry to READY.
REQ-025 In WAIT_* states a0=0 non-ICW1 writes ignored.
REQ-026 READY, a0=1 write: imr<=byte (OCW1).
REQ-027 READY, a0=0, bits4:3=00: ocw2<=byte, ocw2_stb pulse.
REQ-028 READY, a0=0, bits4:3=01 (OCW3): if bit1=1, read select<=bit0 (0 IRR, 1 ISR); bit1=0 keeps select.
REQ-029 Read data: a0=1 -> imr; a0=0 -> irr or isr per select; d_out updated each clk of active read.
REQ-030 INTA: 2-bit pulse counter on s-stage inta_n falling edges; first pulse buf_en=0; second pulse buf_en=1, buf_dir=1, d_out={icw2_base,irq_id} (or 8'h00 if VEC_MODE86=0), inta_ack pulse, counter clears.
REQ-031 INTA overrides rd/wr decode while inta_n sampled low; INTA ignored while init_done=0.

Reset
REQ-032 rst_n low: FSM=WAIT_ICW2... no: FSM=READY, init_done=0, imr=8'hFF, icw2_base=0, ocw2=0, select=IRR, INTA count=0, d_out=0, buf_en=0, buf_dir=0, all pulses 0.
REQ-033 Reset mid-write or mid-INTA discards the pending byte/pulse count.

Configuration
REQ-034 Macro PIC_POLL_CMD_EN defined: OCW3 bit2=1 arms poll; the next a0=0 read returns {irq_valid,4'b0,irq_id}, and inta_ack pulses at its end if irq_valid; poll disarms after that read.
REQ-035 Without PIC_POLL_CMD_EN: OCW3 bit2 ignored, no poll logic.

Structure
REQ-036 Shared package pic_pkg: FSM state enum, read-select enum, OCW/ICW bit-index constants.
REQ-037 One sub-module pic_bus_sync: strobe registering plus rise/fall edge detection.

Verification
REQ-038 ICW1=8'h13, ICW2=8'h20, ICW4=8'h01 -> init_done=1, icw2_base=5'h04, imr=0.
REQ-039 ICW1=8'h11, ICW2, ICW3, ICW4 -> passes WAIT_ICW3; ICW1 again mid-ICW3 -> back to WAIT_ICW2, init_clr pulse.
REQ-040 OCW1=8'hA5 then read a0=1 -> d_out=8'hA5, buf_en=1, buf_dir=1.
REQ-041 OCW3=8'h0B, isr=8'h04, read a0=0 -> 8'h04; OCW3=8'h0A -> irr returned.
REQ-042 Init done, irq_id=3, two INTA pulses -> second drives 8'h23, one inta_ack.
REQ-043 rd_n and wr_n low together -> buf_en=0, imr unchanged; rst_n low mid-write -> imr=8'hFF.
